seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//   Receive-side companion of FourDigitLEDdriver: watches the multiplexed anode/segment bus
//   (an3..an0, a..g, dp) and reconstructs the four displayed characters.
//   Self-checking monitor in benches; on-board readback of the display in hardware.
//   Checks scan legality, settles per digit, decodes glyphs to hex, emits complete frames.
// PARAMETERS
//   SETTLE_CYCLES   4      consecutive cycles anode+segments must be stable before sampling (>=1)
//   TIMEOUT_CYCLES  65536  cycles without a capture before frame is declared stale (>=2)
// PORTS
//   clk          in   1  system clock, all logic on rising edge
//   reset        in   1  asynchronous, active-high; clears all state
//   an3..an0     in   1  each anode enable, active-low, synchronous to clk
//   a..g         in   1  each segment, active-low (0 = lit)
//   dp           in   1  decimal point, active-low
//   char3..char0 out  4  decoded hex code of last captured glyph per digit
//   blank        out  4  bit i = digit i captured all-dark (a..g = 7'b1111111)
//   dp_mask      out  4  bit i = dp lit on digit i at capture
//   frame_strobe out  1  1-cycle pulse: all four digits captured since last strobe
//   frame_valid  out  1  high after first strobe; low while stale
//   stale        out  1  TIMEOUT_CYCLES elapsed with no capture
//   decode_err   out  1  sticky: a settled pattern outside the glyph table
//   scan_err     out  1  sticky: >1 anode low while settled-sampling attempted
//   order_err    out  1  sticky: scan order violation (see CONFIGURATION)
// BEHAVIOUR
//   Reset: all outputs 0, char* = 4'h0, FSM IDLE, captured flags 4'b0000, counters 0.
//   FSM states:
//     IDLE    : no anode low. One-hot-low anode -> SETTLE (count=1). >1 low -> scan_err, stay.
//     SETTLE  : anode+segs+dp identical to previous cycle -> count++; any change -> count=1
//               (new one-hot) or IDLE (none low) or scan_err+IDLE (>1 low).
//               count==SETTLE_CYCLES -> capture this cycle, go CAPTURED.
//     CAPTURED: hold until anode pattern changes, then evaluate as from IDLE.
//               Segment change with same anode: no recapture (first settled value wins).
//   Capture of digit i: glyph table {a..g} active-low -> code:
//     0:0000001 1:1001111 2:0010010 3:0000110 4:1001100 5:0100100 6:0100000 7:0001111
//     8:0000000 9:0000100 A:0001000 b:1100000 C:0110001 d:1000010 E:0110000 F:0111000
//     1111111 -> blank[i]=1, char_i unchanged. Other -> decode_err=1, char_i and blank[i]
//     unchanged, digit not marked captured. Valid capture: char_i/blank[i]/dp_mask[i]
//     registered at the capture edge (visible the cycle after), captured flag i set.
//   Frame: flags==4'b1111 -> frame_strobe next cycle, flags cleared same edge.
//     Recapture of an already-flagged digit before frame completes: overwrite, no strobe.
//   Timeout counter: cleared on every valid capture, saturates at TIMEOUT_CYCLES;
//     reaching it sets stale=1, frame_valid=0, clears flags. Next strobe clears stale.
//   Sticky errors cleared only by reset. Reset mid-settle/mid-frame: state discarded.
//   Min capture latency: SETTLE_CYCLES cycles after anode goes one-hot-low, +1 to outputs.
// CONFIGURATION
//   SEG_SCAN_ORDER_CHECK_EN defined: captures must follow an3->an2->an1->an0->an3 ring;
//     first capture after reset/stale/error may be any digit. Out-of-order capture sets
//     order_err, clears flags, restarts ring from that digit (digit itself captured).
//   Undefined: any order accepted, order_err tied 0, no ring tracking logic.
// TESTING
//   1. Scan "1234" an3..an0, 8 cycles/digit, SETTLE=4 -> char3..0=1,2,3,4, one strobe per
//      full scan, frame_valid=1 after first strobe.
//   2. Segments toggle every 2 cycles for 6 cycles then settle on 7'b0001000 ->
//      capture only after 4 stable cycles, char=A, decode_err=0.
//   3. an=4'b0011 for 5 cycles -> scan_err=1, no capture, flags cleared, strobe absent.
//   4. Pattern 7'b1010101 on an1 -> decode_err=1, char1 unchanged, no strobe that scan;
//      next legal scan still strobes after four new digit captures.
//   5. Stop scanning after a valid frame, TIMEOUT=64 -> stale=1, frame_valid=0 at cycle 64;
//      resume scan -> stale=0 at next strobe.
//   6. Bouncy reset (5/15/5 ns pulses) mid-frame -> all outputs 0; with
//      SEG_SCAN_ORDER_CHECK_EN, scan an3,an1 -> order_err=1.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Receive-side monitor for a multiplexed four-digit seven-segment bus. Watches the
//   active-low anodes and segments, waits for each digit to settle, decodes the glyph
//   to a hex code and reports a frame once all four digits have been captured.
//
// Parameters
//   SETTLE_CYCLES   consecutive identical cycles required before a digit is sampled (>=1)
//   TIMEOUT_CYCLES  cycles without a valid capture before the frame is declared stale (>=2)
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   an3..an0            anode enables, active-low
//   a..g, dp            segments and decimal point, active-low
//   char3..char0        hex code of the last glyph captured on each digit
//   blank               per digit: captured with all segments dark
//   dp_mask             per digit: decimal point lit at capture
//   frame_strobe        one-cycle pulse when all four digits have been captured
//   frame_valid         set by a strobe, cleared when the frame goes stale
//   stale               no valid capture for TIMEOUT_CYCLES
//   decode_err          sticky: settled pattern not in the glyph table
//   scan_err            sticky: more than one anode low
//   order_err           sticky: capture out of an3->an2->an1->an0 ring order
//
// Build option
//   SEG_SCAN_ORDER_CHECK_EN  when defined, enforces the ring scan order; otherwise
//                            order_err is tied low and no ring state exists.
module seg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       an3,
  input  logic       an2,
  input  logic       an1,
  input  logic       an0,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       dp,
  output logic [3:0] char3,
  output logic [3:0] char2,
  output logic [3:0] char1,
  output logic [3:0] char0,
  output logic [3:0] blank,
  output logic [3:0] dp_mask,
  output logic       frame_strobe,
  output logic       frame_valid,
  output logic       stale,
  output logic       decode_err,
  output logic       scan_err,
  output logic       order_err
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] SettleMax = CntW'(SETTLE_CYCLES);
  localparam logic [TmoW-1:0] TmoMax    = TmoW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StSettle, StCaptured} state_e;

  logic [3:0]      an_low;
  logic [7:0]      seg_cur;   // {a..g, dp}
  logic [3:0]      prev_an_q;
  logic [7:0]      prev_seg_q;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            one_hot, multi_low;
  logic [1:0]      dig;
  logic            restart, capture, scan_hit;
  logic            glyph_ok, glyph_blank;
  logic [3:0]      glyph_code;
  logic            valid_cap, bad_cap;

  logic [3:0][3:0] chars_q, chars_d;
  logic [3:0]      blank_q, blank_d;
  logic [3:0]      dpm_q, dpm_d;
  logic [3:0]      flags_q, flags_d;
  logic            strobe_q, strobe_d;
  logic            fvalid_q, fvalid_d;
  logic            stale_q, stale_d;
  logic            derr_q, derr_d;
  logic            serr_q, serr_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
`ifdef SEG_SCAN_ORDER_CHECK_EN
  logic [1:0]      last_q, last_d;
  logic            free_q, free_d;   // next capture may start the ring anywhere
  logic            oerr_q, oerr_d;
`endif

  assign an_low    = ~{an3, an2, an1, an0};
  assign seg_cur   = {a, b, c, d, e, f, g, dp};
  assign one_hot   = (an_low != 4'b0000) && ((an_low & (an_low - 4'd1)) == 4'b0000);
  assign multi_low = (an_low != 4'b0000) && !one_hot;

  always_comb begin
    dig = 2'd0;
    unique case (an_low)
      4'b0010: dig = 2'd1;
      4'b0100: dig = 2'd2;
      4'b1000: dig = 2'd3;
      default: dig = 2'd0;
    endcase
  end

  always_comb begin
    glyph_ok    = 1'b1;
    glyph_code  = 4'h0;
    glyph_blank = (seg_cur[7:1] == 7'b1111111);
    unique case (seg_cur[7:1])
      7'b0000001: glyph_code = 4'h0;
      7'b1001111: glyph_code = 4'h1;
      7'b0010010: glyph_code = 4'h2;
      7'b0000110: glyph_code = 4'h3;
      7'b1001100: glyph_code = 4'h4;
      7'b0100100: glyph_code = 4'h5;
      7'b0100000: glyph_code = 4'h6;
      7'b0001111: glyph_code = 4'h7;
      7'b0000000: glyph_code = 4'h8;
      7'b0000100: glyph_code = 4'h9;
      7'b0001000: glyph_code = 4'hA;
      7'b1100000: glyph_code = 4'hB;
      7'b0110001: glyph_code = 4'hC;
      7'b1000010: glyph_code = 4'hD;
      7'b0110000: glyph_code = 4'hE;
      7'b0111000: glyph_code = 4'hF;
      default:    glyph_ok   = 1'b0;
    endcase
  end

  // Scan FSM: settle counting and capture decision.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    restart  = 1'b0;
    capture  = 1'b0;
    scan_hit = 1'b0;
    case (state_q)
      StIdle: restart = 1'b1;
      StSettle: begin
        if ({an_low, seg_cur} == {prev_an_q, prev_seg_q}) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_d == SettleMax) begin
            capture = 1'b1;
            state_d = StCaptured;
          end
        end else begin
          restart = 1'b1;
        end
      end
      // First settled value wins; only an anode change re-arms sampling.
      StCaptured: if (an_low != prev_an_q) restart = 1'b1;
      default: state_d = StIdle;
    endcase

    if (restart) begin
      if (one_hot) begin
        cnt_d = CntW'(1);
        if (SETTLE_CYCLES == 1) begin
          capture = 1'b1;
          state_d = StCaptured;
        end else begin
          state_d = StSettle;
        end
      end else begin
        cnt_d    = '0;
        state_d  = StIdle;
        scan_hit = multi_low;
      end
    end
  end

  assign valid_cap = capture && (glyph_ok || glyph_blank);
  assign bad_cap   = capture && !(glyph_ok || glyph_blank);

  // Frame assembly, timeout and error flags.
  always_comb begin
    chars_d  = chars_q;
    blank_d  = blank_q;
    dpm_d    = dpm_q;
    flags_d  = flags_q;
    strobe_d = 1'b0;
    fvalid_d = fvalid_q;
    stale_d  = stale_q;
    derr_d   = derr_q;
    serr_d   = serr_q;
    tmo_d    = tmo_q;
`ifdef SEG_SCAN_ORDER_CHECK_EN
    last_d   = last_q;
    free_d   = free_q;
    oerr_d   = oerr_q;
`endif

    if (flags_q == 4'b1111) begin
      flags_d  = 4'b0000;
      strobe_d = 1'b1;
      fvalid_d = 1'b1;
      stale_d  = 1'b0;
    end

    if (scan_hit) begin
      serr_d  = 1'b1;
      flags_d = 4'b0000;
`ifdef SEG_SCAN_ORDER_CHECK_EN
      free_d  = 1'b1;
`endif
    end

    if (bad_cap) begin
      derr_d  = 1'b1;
      flags_d = 4'b0000;
`ifdef SEG_SCAN_ORDER_CHECK_EN
      free_d  = 1'b1;
`endif
    end

    if (valid_cap) begin
`ifdef SEG_SCAN_ORDER_CHECK_EN
      // Ring runs 3->2->1->0->3, so the expected digit is last minus one (mod 4).
      if (!free_q && (dig != last_q - 2'd1)) begin
        oerr_d  = 1'b1;
        flags_d = 4'b0000;
      end
      last_d = dig;
      free_d = 1'b0;
`endif
      flags_d[dig] = 1'b1;
      blank_d[dig] = glyph_blank;
      dpm_d[dig]   = ~dp;
      if (!glyph_blank) chars_d[dig] = glyph_code;
      tmo_d = '0;
    end else if (tmo_q != TmoMax) begin
      tmo_d = tmo_q + TmoW'(1);
    end

    if (tmo_d == TmoMax) begin
      stale_d  = 1'b1;
      fvalid_d = 1'b0;
      flags_d  = 4'b0000;
`ifdef SEG_SCAN_ORDER_CHECK_EN
      free_d   = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      prev_an_q  <= 4'b0000;
      prev_seg_q <= 8'h00;
      chars_q    <= '0;
      blank_q    <= 4'b0000;
      dpm_q      <= 4'b0000;
      flags_q    <= 4'b0000;
      strobe_q   <= 1'b0;
      fvalid_q   <= 1'b0;
      stale_q    <= 1'b0;
      derr_q     <= 1'b0;
      serr_q     <= 1'b0;
      tmo_q      <= '0;
`ifdef SEG_SCAN_ORDER_CHECK_EN
      last_q     <= 2'd0;
      free_q     <= 1'b1;
      oerr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_an_q  <= an_low;
      prev_seg_q <= seg_cur;
      chars_q    <= chars_d;
      blank_q    <= blank_d;
      dpm_q      <= dpm_d;
      flags_q    <= flags_d;
      strobe_q   <= strobe_d;
      fvalid_q   <= fvalid_d;
      stale_q    <= stale_d;
      derr_q     <= derr_d;
      serr_q     <= serr_d;
      tmo_q      <= tmo_d;
`ifdef SEG_SCAN_ORDER_CHECK_EN
      last_q     <= last_d;
      free_q     <= free_d;
      oerr_q     <= oerr_d;
`endif
    end
  end

  assign char3        = chars_q[3];
  assign char2        = chars_q[2];
  assign char1        = chars_q[1];
  assign char0        = chars_q[0];
  assign blank        = blank_q;
  assign dp_mask      = dpm_q;
  assign frame_strobe = strobe_q;
  assign frame_valid  = fvalid_q;
  assign stale        = stale_q;
  assign decode_err   = derr_q;
  assign scan_err     = serr_q;
`ifdef SEG_SCAN_ORDER_CHECK_EN
  assign order_err    = oerr_q;
`else
  assign order_err    = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder: directed scenarios plus randomized bus activity,
// checked every cycle against a run-length based reference model.
`timescale 1ns/1ps
module tb_seg_scan_decoder;

  localparam int unsigned Settle = 4;
  localparam int unsigned Tmo    = 64;
`ifdef SEG_SCAN_ORDER_CHECK_EN
  localparam bit OrderEn = 1'b1;
`else
  localparam bit OrderEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic an3, an2, an1, an0, a, b, c, d, e, f, g, dp;
  logic [3:0] char3, char2, char1, char0, blank, dp_mask;
  logic frame_strobe, frame_valid, stale, decode_err, scan_err, order_err;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .SETTLE_CYCLES (Settle),
    .TIMEOUT_CYCLES(Tmo)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .an3         (an3),
    .an2         (an2),
    .an1         (an1),
    .an0         (an0),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .e           (e),
    .f           (f),
    .g           (g),
    .dp          (dp),
    .char3       (char3),
    .char2       (char2),
    .char1       (char1),
    .char0       (char0),
    .blank       (blank),
    .dp_mask     (dp_mask),
    .frame_strobe(frame_strobe),
    .frame_valid (frame_valid),
    .stale       (stale),
    .decode_err  (decode_err),
    .scan_err    (scan_err),
    .order_err   (order_err)
  );

  int total = 0;
  int bad = 0;
  int strobes = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [6:0] glyph [16];

  function automatic int lookup(input logic [6:0] s);
    for (int k = 0; k < 16; k++) if (glyph[k] == s) return k;
    return -1;
  endfunction

  // ---------------- reference model ----------------
  logic [11:0] m_prev;
  logic [3:0]  m_prev_an;
  bit          m_first;
  int          m_run;
  bit          m_held;     // a capture already happened on the current anode
  logic [3:0]  m_chars [4];
  logic [3:0]  m_blank, m_dpm, m_flags;
  bit          m_strobe, m_fv, m_stale, m_derr, m_serr, m_oerr;
  int          m_cyc, m_lastcap;
`ifdef SEG_SCAN_ORDER_CHECK_EN
  bit          m_free;
  int          m_last;
`endif

  task automatic model_reset();
    m_first = 1'b1; m_run = 0; m_held = 1'b0; m_prev = '0; m_prev_an = '0;
    for (int i = 0; i < 4; i++) m_chars[i] = 4'h0;
    m_blank = '0; m_dpm = '0; m_flags = '0;
    m_strobe = 0; m_fv = 0; m_stale = 0; m_derr = 0; m_serr = 0; m_oerr = 0;
    m_cyc = 0; m_lastcap = 0;
`ifdef SEG_SCAN_ORDER_CHECK_EN
    m_free = 1'b1; m_last = 0;
`endif
  endtask

  task automatic model_step();
    logic [3:0]  an_v;
    logic [6:0]  seg_v;
    logic [11:0] cur;
    int nlow, dg, k;
    bit cap, isblank;
    an_v  = {an3, an2, an1, an0};
    seg_v = {a, b, c, d, e, f, g};
    cur   = {an_v, seg_v, dp};
    nlow  = $countones(~an_v);
    if (m_first || cur != m_prev) m_run = 1;
    else if (m_run < 1000) m_run++;
    if (m_first || an_v != m_prev_an) m_held = 1'b0;
    m_first = 1'b0; m_prev = cur; m_prev_an = an_v;
    cap = (nlow == 1) && !m_held && (m_run == Settle);
    if (cap) m_held = 1'b1;

    m_cyc++;
    m_strobe = 1'b0;
    if (m_flags == 4'hF) begin
      m_strobe = 1'b1; m_flags = '0; m_fv = 1'b1; m_stale = 1'b0;
    end
    if (nlow > 1) begin
      m_serr = 1'b1; m_flags = '0;
`ifdef SEG_SCAN_ORDER_CHECK_EN
      m_free = 1'b1;
`endif
    end
    if (cap) begin
      dg = 0;
      for (int i = 0; i < 4; i++) if (!an_v[i]) dg = i;
      k = lookup(seg_v);
      isblank = (seg_v == 7'h7F);
      if (k < 0 && !isblank) begin
        m_derr = 1'b1; m_flags = '0;
`ifdef SEG_SCAN_ORDER_CHECK_EN
        m_free = 1'b1;
`endif
      end else begin
`ifdef SEG_SCAN_ORDER_CHECK_EN
        if (!m_free && dg != (m_last + 3) % 4) begin
          m_oerr = 1'b1; m_flags = '0;
        end
        m_last = dg; m_free = 1'b0;
`endif
        m_flags[dg] = 1'b1;
        if (!isblank) m_chars[dg] = k[3:0];
        m_blank[dg] = isblank;
        m_dpm[dg] = ~dp;
        m_lastcap = m_cyc;
      end
    end
    if (m_cyc - m_lastcap >= Tmo) begin
      m_stale = 1'b1; m_fv = 1'b0; m_flags = '0;
`ifdef SEG_SCAN_ORDER_CHECK_EN
      m_free = 1'b1;
`endif
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      check("char", {char3, char2, char1, char0},
            {m_chars[3], m_chars[2], m_chars[1], m_chars[0]});
      check("blank", blank, m_blank);
      check("dp_mask", dp_mask, m_dpm);
      check("frame_strobe", frame_strobe, m_strobe);
      check("frame_valid", frame_valid, m_fv);
      check("stale", stale, m_stale);
      check("decode_err", decode_err, m_derr);
      check("scan_err", scan_err, m_serr);
      check("order_err", order_err, m_oerr);
      if (frame_strobe) strobes++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic [3:0] an_v, input logic [6:0] seg_v, input logic dpv,
                      input int n);
    {an3, an2, an1, an0} = an_v;
    {a, b, c, d, e, f, g} = seg_v;
    dp = dpv;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input int c3, input int c2, input int c1, input int c0, input int n);
    hold(4'b0111, glyph[c3], 1'b1, n);
    hold(4'b1011, glyph[c2], 1'b1, n);
    hold(4'b1101, glyph[c1], 1'b1, n);
    hold(4'b1110, glyph[c0], 1'b1, n);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_char"}, {char3, char2, char1, char0}, 32'h0);
    check({tag, "_flags"}, {blank, dp_mask, frame_strobe, frame_valid, stale,
                            decode_err, scan_err, order_err}, 32'h0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s0, r;
    logic [3:0] an_v;
    logic [6:0] seg_v;
    glyph = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
              7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    {an3, an2, an1, an0} = 4'hF;
    {a, b, c, d, e, f, g} = 7'h7F;
    dp = 1'b1;
    #12;
    check_all_zero("reset");
    #11 reset = 1'b0;
    @(negedge clk);
    hold(4'hF, 7'h7F, 1'b1, 2);

    // Scan "1234" twice.
    strobes = 0;
    scan(1, 2, 3, 4, 8);
    scan(1, 2, 3, 4, 8);
    check("t1_chars", {char3, char2, char1, char0}, 32'h1234);
    check("t1_strobes", strobes, 2);
    check("t1_valid", frame_valid, 1'b1);

    // Segment bounce on an2 before settling on 'A'.
    hold(4'b1011, 7'b0000000, 1'b1, 2);
    hold(4'b1011, 7'b0001000, 1'b1, 2);
    hold(4'b1011, 7'b0000000, 1'b1, 2);
    hold(4'b1011, 7'b0001000, 1'b1, 6);
    check("t2_char2", char2, 4'hA);
    check("t2_decode_err", decode_err, 1'b0);

    // Two anodes low.
    hold(4'b0011, glyph[1], 1'b1, 5);
    check("t3_scan_err", scan_err, 1'b1);
    hold(4'hF, 7'h7F, 1'b1, 2);

    // Illegal glyph on an1, then a legal scan.
    s0 = strobes;
    hold(4'b0111, glyph[5], 1'b1, 8);
    hold(4'b1011, glyph[6], 1'b1, 8);
    hold(4'b1101, 7'b1010101, 1'b1, 8);
    hold(4'b1110, glyph[7], 1'b1, 8);
    check("t4_decode_err", decode_err, 1'b1);
    check("t4_char1", char1, 4'h3);
    check("t4_no_strobe", strobes - s0, 0);
    scan(8, 9, 10, 11, 8);
    check("t4_strobe", strobes - s0, 1);

    // Stop scanning until the frame goes stale, then resume.
    hold(4'hF, 7'h7F, 1'b1, 70);
    check("t5_stale", stale, 1'b1);
    check("t5_valid", frame_valid, 1'b0);
    scan(12, 13, 14, 15, 8);
    scan(0, 5, 10, 15, 6);
    check("t5_unstale", stale, 1'b0);
    check("t5_revalid", frame_valid, 1'b1);

    // Randomized bus activity.
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) an_v = ~(4'b0001 << $urandom_range(0, 3));
      else if (r < 90) an_v = 4'hF;
      else begin
        an_v = 4'($urandom);
        while ($countones(~an_v) < 2) an_v = 4'($urandom);
      end
      r = $urandom_range(0, 99);
      if (r < 60) seg_v = glyph[$urandom_range(0, 15)];
      else if (r < 75) seg_v = 7'h7F;
      else seg_v = 7'($urandom);
      hold(an_v, seg_v, 1'($urandom_range(0, 1)), $urandom_range(1, 10));
    end

    // Bouncy reset in the middle of a frame, then an out-of-order pair.
    hold(4'b0111, glyph[1], 1'b1, 8);
    hold(4'b1011, glyph[2], 1'b1, 3);
    #1 reset = 1'b1;
    #5 reset = 1'b0;
    #15 reset = 1'b1;
    #5 reset = 1'b0;
    #1;
    check_all_zero("bounce");
    @(negedge clk);
    hold(4'b0111, glyph[1], 1'b1, 8);
    hold(4'b1101, glyph[3], 1'b1, 8);
    check("t6_order_err", order_err, OrderEn);
    check("t6_char3", char3, 4'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
